proj_qsys_mem_tester: RTL and testbench
=======================================

Name: proj_qsys_mem_tester

Overview:
- Avalon-MM master that drives the s1 port of the single-port on-chip RAM slave: 1024 x 32-bit, read latency 1, no waitrequest.
- On start, it writes an arithmetic pattern over a wrapping address window, reads the window back, and compares each word.
- Reports pass/fail, error count and the first failing address.
- Used as a power-on/bring-up memory self-test alongside the NIOS II in the proj_qsys system.

Parameters:
- ADDR_W, 10, word address width; window wraps modulo 2^ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_WORDS, 1024, upper clamp for word_count (= 2^ADDR_W).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- check_only  in  1  sampled with start; 1 = skip write phase.
- base_addr  in  ADDR_W  first word address of window.
- word_count  in  ADDR_W+1  number of words; values >MAX_WORDS are clamped.
- seed  in  DATA_W  pattern seed.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  valid from done until next accepted start; 1 iff err_count==0.
- err_count  out  ADDR_W+1  mismatching words in last run.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- avm_address  out  ADDR_W  to slave address.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_chipselect  out  1  high in WRITE and READ states.
- avm_write  out  1  high in WRITE only.
- avm_writedata  out  DATA_W  pattern word.
- avm_clken  out  1  constant 1.
- avm_readdata  in  DATA_W  slave q; valid one cycle after a read address is presented.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State is IDLE.
  - Outputs busy, done, pass, err_count, first_err_addr, avm_address, avm_chipselect, avm_write and avm_writedata are all 0.
  - avm_byteenable is all-ones; avm_clken is 1.
- Pattern: word i (0..N-1) = seed + i, mod 2^DATA_W. Address_i = (base_addr + i) mod 2^ADDR_W, so the window wraps 1023 -> 0.
- N = min(word_count, MAX_WORDS), latched at start along with seed, base_addr and check_only.
- States:
  - IDLE: on start -> WRITE, or READ if check_only. Accepting start clears err_count, first_err_addr and pass. If N==0 -> DONE instead.
  - WRITE: one write per cycle, with chipselect=1, write=1, index i=0..N-1. After i=N-1 -> READ with i reset to 0.
  - READ: one read per cycle (chipselect=1, write=0). Expected word and address are delayed one cycle in a pipeline register alongside a compare-valid bit. After i=N-1 -> DRAIN.
  - DRAIN: chipselect=0; compares the final read. -> DONE.
  - DONE: done=1 for exactly one cycle; pass = (err_count==0); busy=0. -> IDLE.
- Compare: when compare-valid is set and avm_readdata != expected, err_count increments. If it was 0 beforehand, first_err_addr is loaded. err_count saturates at all-ones (unreachable for N<=1024).
- Latency, with start accepted at edge 0:
  - Full test: writes on cycles 1..N, reads on cycles N+1..2N, DRAIN at 2N+1, done at 2N+2.
  - check_only: reads 1..N, DRAIN N+1, done N+2.
  - N==0: done at cycle 1 with pass=1.
- busy is high in WRITE, READ and DRAIN.
- start while busy or in DONE is ignored; it is not queued.
- avm_address/avm_writedata are registered outputs; there is no combinational path from inputs to avm_*.
- Reset mid-run: the FSM returns to IDLE immediately, with no done pulse. RAM contents are then undefined to the bench.
- Simultaneous start and reset_n low: reset wins.

Decomposition:
- Package proj_qsys_mem_tester_pkg holds:
  - state enum {IDLE, WRITE, READ, DRAIN, DONE};
  - localparams ADDR_W, DATA_W, MAX_WORDS;
  - a pattern function pat(seed, i).
- One sub-module, proj_qsys_mem_tester_cmp: the one-stage compare pipeline. It holds the valid/expected/address registers, the error counter and first-error capture.

Test Plan:
- base_addr=0x000, word_count=16, seed=0xA5A50000, with behavioural RAM model -> 16 writes with data 0xA5A50000..0xA5A5000F; done at cycle 34; pass=1; err_count=0.
- base_addr=0x3FE, word_count=4, seed=0 -> write addresses 0x3FE, 0x3FF, 0x000, 0x001; pass=1.
- Model corrupts the word at 0x005 (bit 3 flipped) during read, base 0, count 8 -> err_count=1, first_err_addr=0x005, pass=0.
- check_only=1 on preloaded RAM (word k=0x100+k), seed=0x100, count 1024 -> no writes issued; done at cycle 1026; pass=1. Repeat with word_count=2000 -> clamped, identical result.
- word_count=0 -> done at cycle 1; pass=1; chipselect never asserted.
- Assert reset_n=0 at cycle 10 of a 64-word run -> all outputs 0 the same cycle; no done pulse. A new start after release runs cleanly with pass=1.

Source files
------------

// File: rtl/proj_qsys_mem_tester_pkg.sv
// Shared types, sizes and the test-pattern rule for the on-chip RAM self-test master.
package proj_qsys_mem_tester_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 1024;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int BE_W      = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Word i of a run is the seed plus its index, wrapping at the data width.
  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] seed,
                                            input logic [CNT_W-1:0]  i);
    return seed + DATA_W'(i);
  endfunction

endpackage

// File: rtl/proj_qsys_mem_tester_if.sv
// Avalon-MM s1 bundle between the self-test master and the single-port on-chip RAM.
interface proj_qsys_mem_tester_if;
  import proj_qsys_mem_tester_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_byteenable,
    output avm_chipselect,
    output avm_write,
    output avm_writedata,
    output avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_byteenable,
    input  avm_chipselect,
    input  avm_write,
    input  avm_writedata,
    input  avm_clken,
    output avm_readdata
  );

endinterface

// File: rtl/proj_qsys_mem_tester_cmp.sv
// One-stage read-compare pipeline: lines up the expected word with the RAM's
// one-cycle-late readdata, counts mismatches and captures the first bad address.
module proj_qsys_mem_tester_cmp
  import proj_qsys_mem_tester_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_exp,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] readdata,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              valid_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mismatch;

  assign mismatch = valid_q && (readdata != exp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      exp_q          <= '0;
      addr_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      valid_q <= load_valid;
      exp_q   <= load_exp;
      addr_q  <= load_addr;
      if (clear) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        // Only the very first mismatch of a run is allowed to set the address.
        if (err_count == '0) begin
          first_err_addr <= addr_q;
        end
        if (err_count != '1) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/proj_qsys_mem_tester.sv
// Bring-up memory self-test: writes seed+i over a wrapping window of the on-chip
// RAM, reads it back, and reports pass, error count and first failing address.
module proj_qsys_mem_tester
  import proj_qsys_mem_tester_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              check_only,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  proj_qsys_mem_tester_if.master avm
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, n_q, n_in;
  logic [ADDR_W-1:0] base_q, addr_q, addr_d;
  logic [DATA_W-1:0] seed_q, wdata_q, wdata_d;
  logic              pass_q, accept, last;

  assign n_in = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
  assign last = (idx_q == n_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address and write data are precomputed one cycle ahead so the bus stays registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          addr_d  = base_addr;
          wdata_d = seed;
          if (n_in == '0) begin
            state_d = DONE;
          end else if (check_only) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (last) begin
          state_d = READ;
          idx_d   = '0;
          addr_d  = base_q;
          wdata_d = seed_q;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = wdata_q + DATA_W'(1);
        end
      end
      READ: begin
        if (last) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idx_q + CNT_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (accept) begin
        n_q    <= n_in;
        base_q <= base_addr;
        seed_q <= seed;
        pass_q <= 1'b0;
      end else if (state_q == DONE) begin
        pass_q <= (err_count == '0);
      end
    end
  end

  proj_qsys_mem_tester_cmp u_cmp (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (accept),
    .load_valid     (state_q == READ),
    .load_exp       (pat(seed_q, idx_q)),
    .load_addr      (addr_q),
    .readdata       (avm.avm_readdata),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  // The final compare lands on the DRAIN->DONE edge, so pass in DONE reads the live count.
  assign busy = state_q inside {WRITE, READ, DRAIN};
  assign done = (state_q == DONE);
  assign pass = done ? (err_count == '0) : pass_q;

  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = '1;
  assign avm.avm_chipselect = (state_q == WRITE) || (state_q == READ);
  assign avm.avm_write      = (state_q == WRITE);
  assign avm.avm_clken      = 1'b1;

endmodule

// File: tb/tb_proj_qsys_mem_tester.sv
// Randomized self-checking bench for the RAM self-test master, with a behavioural
// 1024x32 RAM slave and a spec-level model of what each run should report.
module tb_proj_qsys_mem_tester;
  import proj_qsys_mem_tester_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic              check_only = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;

  proj_qsys_mem_tester_if bus();

  proj_qsys_mem_tester dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .check_only     (check_only),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:1023];
  logic [31:0] shadow  [0:1023];
  logic [31:0] corrupt [0:1023];

  // RAM slave: read latency 1, optional bit corruption on the read path.
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write) begin
      mem[bus.avm_address] <= bus.avm_writedata;
    end
    bus.avm_readdata <= mem[bus.avm_address] ^ corrupt[bus.avm_address];
  end

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_err"}, err_count, 0);
    checkOutput({tag, "_first"}, first_err_addr, 0);
    checkOutput({tag, "_bus"}, {bus.avm_address, bus.avm_chipselect, bus.avm_write, bus.avm_writedata}, 0);
    checkOutput({tag, "_be_clken"}, {bus.avm_byteenable, bus.avm_clken}, 5'h1F);
  endtask

  task automatic clearCorrupt();
    for (int k = 0; k < 1024; k++) corrupt[k] = '0;
  endtask

  // One run: model predicts results from the spec rules, then the DUT is observed.
  task automatic applyStimulus(input bit chk, input int base, input int cnt,
                               input logic [31:0] sd, input int abort_at);
    int n, exp_err, exp_first, exp_done, a;
    int wr_cnt, rd_cnt, cs_cnt, wr_bad, rd_bad, busy_bad, done_cyc, rst_done;
    logic [31:0] rd, ew;
    logic pass_s;
    logic [CNT_W-1:0] err_s;
    logic [ADDR_W-1:0] first_s;
    bit seen;

    n = (cnt > MAX_WORDS) ? MAX_WORDS : cnt;
    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < n; i++) begin
      a  = (base + i) % 1024;
      ew = sd + i;
      rd = (chk ? shadow[a] : ew) ^ corrupt[a];
      if (rd != ew) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    exp_done = (n == 0) ? 1 : (chk ? n + 2 : 2 * n + 2);

    @(negedge clk);
    start      = 1'b1;
    check_only = chk;
    base_addr  = base[ADDR_W-1:0];
    word_count = cnt[CNT_W-1:0];
    seed       = sd;
    @(posedge clk);

    wr_cnt = 0; rd_cnt = 0; cs_cnt = 0; wr_bad = 0; rd_bad = 0; busy_bad = 0;
    done_cyc = 0; seen = 1'b0; pass_s = 1'b0; err_s = '0; first_s = '0;
    for (int cyc = 1; cyc <= 2 * MAX_WORDS + 8 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start      = 1'b0;
        check_only = $urandom_range(0, 1);
        base_addr  = ADDR_W'($urandom);
        word_count = CNT_W'($urandom);
        seed       = $urandom;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        reset_n = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        rst_done = 0;
        repeat (3) begin
          @(negedge clk);
          if (done) rst_done++;
        end
        checkOutput("midrst_no_done", rst_done, 0);
        reset_n = 1'b1;
        return;
      end
      if (bus.avm_chipselect) cs_cnt++;
      if (bus.avm_chipselect && bus.avm_write) begin
        a = (base + wr_cnt) % 1024;
        if (bus.avm_address != ADDR_W'(a) || bus.avm_writedata != sd + wr_cnt) wr_bad++;
        wr_cnt++;
      end
      if (bus.avm_chipselect && !bus.avm_write) begin
        a = (base + rd_cnt) % 1024;
        if (bus.avm_address != ADDR_W'(a)) rd_bad++;
        rd_cnt++;
      end
      if (done) begin
        seen = 1'b1; done_cyc = cyc; pass_s = pass; err_s = err_count; first_s = first_err_addr;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
    end

    checkOutput("done_seen", seen, 1);
    if (!seen) return;
    checkOutput("done_cycle", done_cyc, exp_done);
    checkOutput("pass", pass_s, exp_err == 0);
    checkOutput("err_count", err_s, exp_err);
    checkOutput("first_err_addr", first_s, exp_first);
    checkOutput("write_count", wr_cnt, chk ? 0 : n);
    checkOutput("read_count", rd_cnt, n);
    checkOutput("cs_cycles", cs_cnt, chk ? n : 2 * n);
    checkOutput("write_seq", wr_bad, 0);
    checkOutput("read_seq", rd_bad, 0);
    checkOutput("busy_window", busy_bad, 0);
    @(negedge clk);
    checkOutput("done_pulse", {done, busy}, 0);
    checkOutput("pass_hold", pass, exp_err == 0);

    if (!chk) begin
      for (int i = 0; i < n; i++) shadow[(base + i) % 1024] = sd + i;
    end
  endtask

  initial begin
    int base, cnt, nc;
    bit chk;
    clearCorrupt();
    for (int k = 0; k < 1024; k++) shadow[k] = '0;

    $display("[TB] reset check");
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b0, 'h000, 16, 32'hA5A50000, 0);
    applyStimulus(1'b0, 'h3FE, 4, 32'h0, 0);

    corrupt[5] = 32'h8;
    applyStimulus(1'b0, 'h000, 8, $urandom, 0);
    clearCorrupt();

    applyStimulus(1'b0, 'h000, 1024, 32'h100, 0);
    applyStimulus(1'b1, 'h000, 1024, 32'h100, 0);
    applyStimulus(1'b1, 'h000, 2000, 32'h100, 0);

    applyStimulus(1'b0, 'h123, 0, $urandom, 0);

    applyStimulus(1'b0, 'h200, 64, 32'hC0DE0000, 10);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 'h200, 64, 32'hC0DE0000, 0);

    for (int r = 0; r < 10; r++) begin
      chk  = (r % 3 == 2);
      base = $urandom_range(0, 1023);
      cnt  = $urandom_range(0, 40);
      nc   = (cnt == 0) ? 0 : $urandom_range(0, 2);
      for (int c = 0; c < nc; c++) begin
        corrupt[(base + $urandom_range(0, cnt - 1)) % 1024] = 32'h1 << $urandom_range(0, 31);
      end
      applyStimulus(chk, base, cnt, chk ? $urandom_range(0, 3) + 32'h100 + 32'(base) : $urandom, 0);
      clearCorrupt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
